// File: rtl/epd_init_seq.sv
// SSD1683 e-paper init sequencer: walks the init ROM and sends each entry as one SPI mode-0 byte.
// Optional BUSY-wait watchdog is enabled with macro EPD_BUSY_TIMEOUT_EN.
module epd_init_seq #(
  parameter int CLK_DIV = 2,
  parameter int SEQ_LEN = 21
`ifdef EPD_BUSY_TIMEOUT_EN
  ,
  parameter int BUSY_TIMEOUT = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_cmd,
  input  logic       rom_is_data,
  input  logic       epd_busy,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_dc,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_WAIT_BUSY,
    S_DONE
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [7:0]  ADDR_LAST = 8'(SEQ_LEN - 1);
  localparam logic [7:0]  CMD_SWRESET = 8'h12;

  state_t      state;
  logic        busy_meta;
  logic        busy_sync;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;      // bit 7 goes straight to mosi at fetch
  logic        wait_req;
  logic        div_done;
  logic        step;

  assign div_done = (div_cnt == DIV_LAST);

  // GAP and WAIT_BUSY share one "move to next entry" decision.
  assign step = ((state == S_GAP) && div_done && !wait_req) ||
                ((state == S_WAIT_BUSY) && !busy_sync);

`ifdef EPD_BUSY_TIMEOUT_EN
  localparam logic [15:0] TOUT_LAST = 16'(BUSY_TIMEOUT - 1);
  logic [15:0] tout_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // a later assignment in the same block (the step block) intentionally overrides earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
      state     <= S_IDLE;
      rom_addr  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wait_req  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_dc    <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
`ifdef EPD_BUSY_TIMEOUT_EN
      tout_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      busy_meta <= epd_busy;
      busy_sync <= busy_meta;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rom_addr <= '0;
            seq_busy <= 1'b1;
            seq_done <= 1'b0;
`ifdef EPD_BUSY_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          shreg    <= rom_cmd[6:0];
          spi_dc   <= rom_is_data;
          wait_req <= !rom_is_data && (rom_cmd == CMD_SWRESET);
          spi_mosi <= rom_cmd[7];
          spi_cs_n <= 1'b0;
          div_cnt  <= '0;
          state    <= S_LOAD;
        end

        S_LOAD: begin
          if (div_done) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            spi_sclk <= 1'b1;
            state    <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end

        S_SHIFT: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (spi_sclk) begin
              // Falling edge: present the next bit for the following rising edge.
              spi_sclk <= 1'b0;
              spi_mosi <= shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
            end else if (bit_cnt == 3'd7) begin
              spi_cs_n <= 1'b1;
              state    <= S_GAP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              spi_sclk <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 16'd1;
          end else if (wait_req) begin
            div_cnt <= '0;
            state   <= S_WAIT_BUSY;
`ifdef EPD_BUSY_TIMEOUT_EN
            tout_cnt <= '0;
`endif
          end
        end

        S_WAIT_BUSY: begin
`ifdef EPD_BUSY_TIMEOUT_EN
          if (busy_sync) begin
            if (tout_cnt == TOUT_LAST) begin
              err_timeout <= 1'b1;
              seq_busy    <= 1'b0;
              seq_done    <= 1'b1;
              state       <= S_DONE;
            end else begin
              tout_cnt <= tout_cnt + 16'd1;
            end
          end
`endif
        end

        default: state <= S_IDLE;
      endcase

      if (step) begin
        if (rom_addr == ADDR_LAST) begin
          seq_busy <= 1'b0;
          seq_done <= 1'b1;
          state    <= S_DONE;
        end else begin
          rom_addr <= rom_addr + 8'd1;
          state    <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_epd_init_seq.sv
// Randomised bench for epd_init_seq: decodes the SPI pins into frames and compares them with the ROM order.
// Runs the BUSY watchdog scenario only when EPD_BUSY_TIMEOUT_EN is defined.
module tb_epd_init_seq;

  localparam int CLK_DIV   = 2;
  localparam int SEQ_LEN   = 21;
  localparam int FRAME_LOW = CLK_DIV * 17;

  localparam logic [8:0] STD_ROM [SEQ_LEN] = '{
    9'h012, 9'h021, 9'h140, 9'h100, 9'h001, 9'h12B, 9'h101, 9'h100,
    9'h011, 9'h103, 9'h044, 9'h100, 9'h131, 9'h045, 9'h100, 9'h100,
    9'h12B, 9'h101, 9'h04F, 9'h100, 9'h100
  };

  logic       clk, rst_n, start, epd_busy;
  logic [7:0] rom_addr, rom_cmd;
  logic       rom_is_data;
  logic       spi_cs_n, spi_sclk, spi_mosi, spi_dc;
  logic       seq_busy, seq_done, err_timeout;

  logic [8:0] rom_mem [256];   // {is_data, byte}
  assign rom_cmd     = rom_mem[rom_addr][7:0];
  assign rom_is_data = rom_mem[rom_addr][8];

  epd_init_seq #(.CLK_DIV(CLK_DIV), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_cmd(rom_cmd), .rom_is_data(rom_is_data),
    .epd_busy(epd_busy),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .seq_busy(seq_busy), .seq_done(seq_done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [8:0] val;
    int nbits;
    int low_len;
    int gap;
    int end_cyc;
    bit dc_bad;
    bit hi_bad;
  } frame_t;

  frame_t frames[$];
  int     nstart;
  int     last_fall_cyc;
  int     cyc = 0;
  bit     addr_bad;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI frame decoder, sampled on the falling clk edge.
  initial begin
    bit     prev_cs, prev_sclk;
    logic   hi_mosi;
    int     hi_len;
    frame_t cur;
    prev_cs = 1'b1; prev_sclk = 1'b0; hi_mosi = 1'b0; hi_len = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (rom_addr > 8'(SEQ_LEN - 1)) addr_bad = 1'b1;
      if (prev_cs && !spi_cs_n) begin
        cur = '{default: 0};
        cur.val[8] = spi_dc;
        cur.gap = hi_len;
        nstart++;
        last_fall_cyc = cyc;
      end
      if (!spi_cs_n) begin
        hi_len = 0;
        cur.low_len++;
        if (spi_dc !== cur.val[8]) cur.dc_bad = 1'b1;
        if (spi_sclk && !prev_sclk) begin
          cur.val[7:0] = {cur.val[6:0], spi_mosi};
          cur.nbits++;
          hi_mosi = spi_mosi;
        end else if (spi_sclk && (spi_mosi !== hi_mosi)) begin
          cur.hi_bad = 1'b1;
        end
      end else begin
        hi_len++;
      end
      if (!prev_cs && spi_cs_n && rst_n) begin
        cur.end_cyc = cyc;
        frames.push_back(cur);
      end
      prev_cs = spi_cs_n;
      prev_sclk = spi_sclk;
    end
  end

  function automatic bit is_wait(input int idx);
    return rom_mem[idx] == 9'h012;
  endfunction

  task automatic load_std();
    for (int i = 0; i < 256; i++) rom_mem[i] = (i < SEQ_LEN) ? STD_ROM[i] : 9'h1FF;
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) rom_mem[i] = 9'h1FF;
    for (int i = 0; i < SEQ_LEN; i++) rom_mem[i] = {1'($urandom_range(1)), 8'($urandom)};
    rom_mem[$urandom_range(SEQ_LEN - 2)] = 9'h012;
    rom_mem[$urandom_range(SEQ_LEN - 1)] = 9'h112;
    rom_mem[$urandom_range(SEQ_LEN - 2)] = 9'h012;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  // One full sequence; hold = cycles BUSY stays high after each soft-reset frame ends.
  task automatic run_seq(input int hold, input bit pulses, input string nm);
    logic [8:0] exp_q[$];
    int seen_start, hold_cnt, rel_cyc, collide_step, budget;
    for (int i = 0; i < SEQ_LEN; i++) exp_q.push_back(rom_mem[i]);
    frames.delete();
    nstart = 0; addr_bad = 1'b0;
    seen_start = 0; hold_cnt = 0; rel_cyc = -1; collide_step = 0; budget = 0;
    epd_busy = 1'b0;
    pulse_start();
    check({nm, "_accept_busy"}, seq_busy, 1);
    check({nm, "_accept_done"}, seq_done, 0);
    check({nm, "_accept_err"}, err_timeout, 0);
    check({nm, "_accept_addr"}, rom_addr, 0);
    while (budget < 30000) begin
      @(negedge clk); #1;
      budget++;
      if (seq_done) begin
        start = 1'b0;
        break;
      end
      start = pulses && ($urandom_range(40) == 0);
      if (nstart > seen_start) begin
        seen_start = nstart;
        if (rel_cyc >= 0) begin
          check({nm, "_release_lat"},
                (last_fall_cyc - rel_cyc >= 3) && (last_fall_cyc - rel_cyc <= 4), 1);
          rel_cyc = -1;
        end
        if (hold > 0 && seen_start <= SEQ_LEN && is_wait(seen_start - 1)) begin
          epd_busy = 1'b1;
          hold_cnt = hold;
        end
      end
      if (epd_busy && frames.size() >= seen_start) begin
        if (hold_cnt == 0) begin
          epd_busy = 1'b0;
          rel_cyc = cyc;
        end else begin
          hold_cnt--;
        end
      end
      // Start asserted on the edge where DONE is entered must be ignored.
      if (frames.size() == SEQ_LEN && !is_wait(SEQ_LEN - 1)) begin
        collide_step++;
        if (collide_step == 2) start = 1'b1;
      end
    end
    start = 1'b0;
    check({nm, "_done"}, seq_done, 1);
    repeat (40) @(negedge clk);
    check({nm, "_frame_count"}, frames.size(), SEQ_LEN);
    for (int i = 0; i < SEQ_LEN && i < frames.size(); i++) begin
      check($sformatf("%s_f%0d_val", nm, i), frames[i].val, exp_q[i]);
      check($sformatf("%s_f%0d_bits", nm, i), frames[i].nbits, 8);
      check($sformatf("%s_f%0d_low", nm, i), frames[i].low_len, FRAME_LOW);
      check($sformatf("%s_f%0d_stable", nm, i), frames[i].dc_bad || frames[i].hi_bad, 0);
      if (i > 0) check($sformatf("%s_f%0d_gap", nm, i), frames[i].gap >= 2, 1);
    end
    check({nm, "_end_addr"}, rom_addr, SEQ_LEN - 1);
    check({nm, "_addr_range"}, addr_bad, 0);
    check({nm, "_end_busy"}, seq_busy, 0);
    check({nm, "_end_done"}, seq_done, 1);
    check({nm, "_end_pins"}, {spi_cs_n, spi_sclk}, 2'b10);
    check({nm, "_end_err"}, err_timeout, 0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_cs_n"}, spi_cs_n, 1);
    check({nm, "_sclk"}, spi_sclk, 0);
    check({nm, "_mosi"}, spi_mosi, 0);
    check({nm, "_dc"}, spi_dc, 0);
    check({nm, "_busy"}, seq_busy, 0);
    check({nm, "_done"}, seq_done, 0);
    check({nm, "_err"}, err_timeout, 0);
    check({nm, "_addr"}, rom_addr, 0);
  endtask

  task automatic reset_mid_frame();
    int budget, snap;
    load_std();
    frames.delete(); nstart = 0; epd_busy = 1'b0;
    pulse_start();
    budget = 0;
    while (nstart < 6 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("rst_mid_reach_f5", nstart >= 6, 1);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_cs_immediate", spi_cs_n, 1);
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom_range(1));
      epd_busy = 1'($urandom_range(1));
    end
    check_reset_state("rst_mid");
    start = 1'b0; epd_busy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    snap = nstart;
    repeat (60) @(negedge clk);
    check("rst_mid_no_restart", nstart, snap);
    check("rst_mid_idle_busy", seq_busy, 0);
    run_seq(0, 1'b0, "replay");
  endtask

`ifdef EPD_BUSY_TIMEOUT_EN
  task automatic timeout_run();
    int budget;
    load_std();
    frames.delete(); nstart = 0;
    epd_busy = 1'b1;
    pulse_start();
    budget = 0;
    while (!seq_done && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("tout_done", seq_done, 1);
    check("tout_err", err_timeout, 1);
    check("tout_frames", frames.size(), 1);
    if (frames.size() > 0)
      check("tout_delay", (cyc - frames[0].end_cyc >= 995) && (cyc - frames[0].end_cyc <= 1010), 1);
    repeat (50) @(negedge clk);
    check("tout_no_more_frames", frames.size(), 1);
    check("tout_err_sticky", err_timeout, 1);
    epd_busy = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; epd_busy = 1'b0;
    load_std();
    repeat (8) begin
      @(negedge clk);
      start = 1'($urandom_range(1));
      epd_busy = 1'($urandom_range(1));
    end
    check_reset_state("reset");
    start = 1'b0; epd_busy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_seq(0, 1'b0, "std");
    run_seq(200, 1'b0, "hold");
    for (int r = 0; r < 3; r++) begin
      load_random();
      run_seq($urandom_range(0, 150), 1'b1, $sformatf("rnd%0d", r));
    end
    reset_mid_frame();
`ifdef EPD_BUSY_TIMEOUT_EN
    timeout_run();
    load_std();
    run_seq(0, 1'b0, "after_tout");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
